// File: rtl/adma_descriptor_engine.sv
// ADMA descriptor engine: fetches 96-bit descriptors, follows links and launches data transfers.
// Latency: fetch request the cycle after a start; tfr_start/int_out are registered (one cycle after decode/done).
// Backpressure: desc_req holds until desc_ack; ST_TFR waits on tfr_done; STOP parks the engine at the held pointer.
module adma_descriptor_engine #(
  parameter int DESC_STRIDE = 12
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STOP,
  input  logic        command_reg_write,
  input  logic        command_reg_continue,
  input  logic        direction,
  input  logic [63:0] starting_address,
  output logic        desc_req,
  output logic [63:0] desc_addr,
  input  logic        desc_ack,
  input  logic [95:0] address_descriptor,
  output logic        tfr_start,
  output logic [63:0] tfr_addr,
  output logic [16:0] tfr_len,
  output logic        tfr_dir,
  input  logic        tfr_done,
  output logic        int_out,
  output logic        adma_error,
  output logic [1:0]  error_state,
  output logic        busy,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_FDS  = 2'd1;
  localparam logic [1:0] ST_CADR = 2'd2;
  localparam logic [1:0] ST_TFR  = 2'd3;

  localparam logic [1:0] ACT_NOP  = 2'b00;
  localparam logic [1:0] ACT_RSV  = 2'b01;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [63:0] r_ptr;
  logic        r_stopped;

  // Latched descriptor fields
  logic [63:0] r_d_addr;
  logic [15:0] r_d_len;
  logic        r_d_valid;
  logic        r_d_end;
  logic        r_d_int;
  logic [1:0]  r_d_act;

  logic        r_tfr_start;
  logic [63:0] r_tfr_addr;
  logic [16:0] r_tfr_len;
  logic        r_tfr_dir;
  logic        r_int_out;
  logic        r_err;
  logic [1:0]  r_err_state;

  logic        w_start;
  logic        w_resume;
  logic [63:0] w_ptr_inc;
  logic        w_unused;

  // Attribute bits with no meaning to this engine
  assign w_unused  = ^{address_descriptor[15:6], address_descriptor[3]};

  // A new start always takes priority over a resume
  assign w_start   = command_reg_write && !STOP;
  assign w_resume  = !command_reg_write && command_reg_continue && r_stopped && !STOP;
  assign w_ptr_inc = r_ptr + 64'(DESC_STRIDE);

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= ST_STOP;
    else        r_state <= w_next_state;
  end

  // Next-state logic; STOP overrides everything outside ST_STOP
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_STOP: if (w_start || w_resume) w_next_state = ST_FDS;
      ST_FDS: begin
        if (STOP)          w_next_state = ST_STOP;
        else if (desc_ack) w_next_state = ST_CADR;
      end
      ST_CADR: begin
        if (STOP || !r_d_valid)       w_next_state = ST_STOP;
        else if (r_d_act == ACT_TRAN) w_next_state = ST_TFR;
        else if (r_d_end)             w_next_state = ST_STOP;
        else                          w_next_state = ST_FDS;
      end
      ST_TFR: begin
        if (STOP)          w_next_state = ST_STOP;
        else if (tfr_done) w_next_state = r_d_end ? ST_STOP : ST_FDS;
      end
      default: w_next_state = ST_STOP;
    endcase
  end

  // Outputs derived directly from the current state and pointer
  always_comb begin
    desc_req  = (r_state == ST_FDS);
    desc_addr = r_ptr;
    busy      = (r_state != ST_STOP);
    state     = r_state;
  end

  // Pointer, descriptor latch, stop flag, error and transfer/interrupt registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_ptr       <= '0;
      r_stopped   <= 1'b0;
      r_d_addr    <= '0;
      r_d_len     <= '0;
      r_d_valid   <= 1'b0;
      r_d_end     <= 1'b0;
      r_d_int     <= 1'b0;
      r_d_act     <= ACT_NOP;
      r_tfr_start <= 1'b0;
      r_tfr_addr  <= '0;
      r_tfr_len   <= '0;
      r_tfr_dir   <= 1'b0;
      r_int_out   <= 1'b0;
      r_err       <= 1'b0;
      r_err_state <= '0;
    end else begin
      r_tfr_start <= 1'b0;
      r_int_out   <= 1'b0;
      case (r_state)
        ST_STOP: begin
          if (w_start) begin
            r_ptr       <= starting_address;
            r_err       <= 1'b0;
            r_err_state <= '0;
            r_stopped   <= 1'b0;
          end else if (w_resume) begin
            r_stopped <= 1'b0;
          end
        end
        ST_FDS: begin
          if (STOP) begin
            r_stopped <= 1'b1;
          end else if (desc_ack) begin
            r_d_addr  <= address_descriptor[95:32];
            r_d_len   <= address_descriptor[31:16];
            r_d_act   <= address_descriptor[5:4];
            r_d_int   <= address_descriptor[2];
            r_d_end   <= address_descriptor[1];
            r_d_valid <= address_descriptor[0];
          end
        end
        ST_CADR: begin
          if (STOP) begin
            r_stopped <= 1'b1;
          end else if (!r_d_valid) begin
            // Error code 1: invalid descriptor met during address decode
            r_err       <= 1'b1;
            r_err_state <= 2'd1;
          end else begin
            case (r_d_act)
              ACT_NOP: begin
                r_ptr     <= w_ptr_inc;
                r_int_out <= r_d_int;
              end
              ACT_RSV: r_ptr <= w_ptr_inc;
              ACT_LINK: begin
                r_ptr     <= r_d_addr;
                r_int_out <= r_d_int;
              end
              default: begin
                r_tfr_start <= 1'b1;
                r_tfr_addr  <= r_d_addr;
                r_tfr_dir   <= direction;
                r_tfr_len   <= (r_d_len == 16'd0) ? 17'h10000 : {1'b0, r_d_len};
              end
            endcase
          end
        end
        default: begin
          // ST_TFR: a completing transfer is retired even when STOP arrives with it
          if (tfr_done) begin
            r_ptr     <= w_ptr_inc;
            r_int_out <= r_d_int;
          end
          if (STOP) r_stopped <= 1'b1;
        end
      endcase
    end
  end

  assign tfr_start   = r_tfr_start;
  assign tfr_addr    = r_tfr_addr;
  assign tfr_len     = r_tfr_len;
  assign tfr_dir     = r_tfr_dir;
  assign int_out     = r_int_out;
  assign adma_error  = r_err;
  assign error_state = r_err_state;

endmodule

// File: doc/adma_descriptor_engine.md
ADMA_DESCRIPTOR_ENGINE -- requirements
Module: adma_descriptor_engine

Interface
REQ-001 Parameter DESC_STRIDE, default 12, byte increment of the descriptor pointer per 96-bit descriptor.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
REQ-004 STOP  input  1  stop request; level-sensitive.
REQ-005 command_reg_write  input  1  start request; loads the descriptor pointer from starting_address.
REQ-006 command_reg_continue  input  1  resume request after a stop.
REQ-007 direction  input  1  transfer direction (1 = write to card, 0 = read from card), passed to tfr_dir.
REQ-008 starting_address  input  64  address of the first descriptor.
REQ-009 desc_req  output  1  descriptor fetch request.
REQ-010 desc_addr  output  64  address of the descriptor being fetched.
REQ-011 desc_ack  input  1  fetch acknowledge; address_descriptor is valid in the same cycle.
REQ-012 address_descriptor  input  96  descriptor fields: [95:32] address, [31:16] length, [15:0] attribute (bit0 valid, bit1 end, bit2 int, bits5:4 act).
REQ-013 tfr_start  output  1  one-cycle data-transfer start pulse.
REQ-014 tfr_addr  output  64  transfer address.
REQ-015 tfr_len  output  17  transfer length in bytes.
REQ-016 tfr_dir  output  1  transfer direction.
REQ-017 tfr_done  input  1  transfer-complete pulse.
REQ-018 int_out  output  1  one-cycle descriptor interrupt pulse.
REQ-019 adma_error  output  1  sticky error flag.
REQ-020 error_state  output  2  state code in which the error was detected.
REQ-021 busy  output  1  high while state is not ST_STOP.
REQ-022 state  output  2  current state: ST_STOP=0, ST_FDS=1, ST_CADR=2, ST_TFR=3.

Function
REQ-023 ST_STOP: command_reg_write=1 with STOP=0 -> pointer loads starting_address, adma_error and error_state clear, next state ST_FDS.
REQ-024 Timing: command_reg_write sampled in cycle N -> state=ST_FDS, desc_req=1 and desc_addr=pointer in cycle N+1.
REQ-025 command_reg_write outside ST_STOP is ignored.
REQ-026 ST_FDS: desc_req held high until desc_ack.
REQ-027 On desc_ack: descriptor latched, desc_req=0 in the next cycle, next state ST_CADR.
REQ-028 ST_CADR lasts exactly one cycle.
REQ-029 ST_CADR with valid=0: adma_error=1, error_state=1, next state ST_STOP, pointer unchanged.
REQ-030 ST_CADR with act=00 (nop) or act=01 (reserved): pointer += DESC_STRIDE.
REQ-031 ST_CADR with act=11 (link): pointer = descriptor address field.
REQ-032 After nop, reserved or link: next state is ST_STOP if end=1, else ST_FDS.
REQ-033 ST_CADR with act=10 (tran): tfr_addr=address field, tfr_dir=direction, tfr_len=length field (0 means 65536), one-cycle tfr_start pulse, next state ST_TFR.
REQ-034 ST_TFR waits for tfr_done; then pointer += DESC_STRIDE, next state ST_STOP if end=1, else ST_FDS.
REQ-035 int_out pulses for exactly one cycle when a descriptor with int=1 completes: in ST_CADR for nop/link, on tfr_done for tran.
REQ-036 Pointer arithmetic is 64-bit modulo 2^64; wrap-around is not an error.
REQ-037 STOP=1 in any state except ST_STOP: next state ST_STOP, desc_req=0, a stopped flag sets, pointer is held.
REQ-038 STOP and desc_ack in the same cycle: STOP wins and the descriptor is discarded.
REQ-039 STOP and tfr_done in the same cycle: the descriptor is completed (pointer advance, int_out) before entering ST_STOP.
REQ-040 command_reg_continue in ST_STOP with the stopped flag set and STOP=0: flag clears, next state ST_FDS at the held pointer; otherwise command_reg_continue is ignored.
REQ-041 If command_reg_write and command_reg_continue are high together, command_reg_write wins.

Reset
REQ-042 RESET=0 at a rising edge: state=ST_STOP, pointer=0, stopped flag=0, and every output is 0 (desc_req, desc_addr, tfr_start, tfr_addr, tfr_len, tfr_dir, int_out, adma_error, error_state, busy).
REQ-043 Reset mid-operation aborts any fetch or transfer immediately, with no int_out or error generated.

Verification
REQ-044 Start at 0x1000; descriptor tran, addr 0x8000, length 0x0200, end=1, int=1; tfr_done 5 cycles later -> tfr_start with tfr_addr=0x8000 and tfr_len=0x200, then int_out pulse, then ST_STOP with busy=0.
REQ-045 Chain: tran (end=0), then link to 0x2000, then tran (end=1) -> desc_addr sequence 0x1000, 0x100C, 0x2000; two tfr_start pulses.
REQ-046 Descriptor with valid=0 at first fetch -> adma_error=1, error_state=1, ST_STOP; next command_reg_write clears the error.
REQ-047 STOP asserted in ST_TFR, then command_reg_continue -> return to ST_STOP, then refetch at the advanced pointer if tfr_done coincided with STOP, else at the held pointer.
REQ-048 starting_address=0xFFFF_FFFF_FFFF_FFF8 with a nop descriptor, end=0 -> next desc_addr=0x0000_0000_0000_0004.
REQ-049 RESET=0 asserted while desc_req=1 -> all outputs 0 on the next cycle.
